// File: rtl/debug_monitor.sv
// ============================================================================
// Module      : debug_monitor
// Description : Bring-up test monitor: pass/fail verdict, console FIFO,
//               cycle watchdog and done flags. Optional DEBUG_MONITOR_FINISH_EN
//               prints console bytes and ends the simulation on DONE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_monitor #(
  parameter int          ADDR_W       = 2,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] PASS_VALUE   = 32'h1,
  parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD0001
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              csb_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic              data_wen_i,
  output logic [31:0]       data_o,
  output logic              char_valid_o,
  output logic [7:0]        char_o,
  input  logic              char_ready_i,
  output logic              done_o,
  output logic              pass_o,
  output logic [31:0]       code_o
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_FCNT_W = c_PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_limit;
  logic                r_pass;
  logic [31:0]         r_code;
  logic                r_timeout;
  logic                r_ovf;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_FCNT_W-1:0] r_fifo_cnt;

  logic w_wr, w_rd, w_in_run;
  logic w_wr_result, w_wr_console, w_wr_timeout;
  logic w_expire, w_full, w_empty, w_pop, w_push;
  logic [31:0] w_status;

  assign w_wr     = !csb_i && !data_wen_i;
  assign w_rd     = !csb_i &&  data_wen_i;
  assign w_in_run = (r_state == ST_RUN);

  assign w_wr_result  = w_wr && w_in_run && (addr_i == ADDR_W'(0));
  assign w_wr_console = w_wr && w_in_run && (addr_i == ADDR_W'(1));
  assign w_wr_timeout = w_wr && w_in_run && (addr_i == ADDR_W'(2));

  // A TIMEOUT write reloads the watchdog, so it masks expiry in that cycle
  assign w_expire = w_in_run && !w_wr_timeout && (r_limit != '0) &&
                    (r_cnt == r_limit - CNT_W'(1));

  assign w_empty = (r_fifo_cnt == '0);
  assign w_full  = (r_fifo_cnt == c_FCNT_W'(FIFO_DEPTH));
  assign w_pop   = !w_empty && char_ready_i;
  assign w_push  = w_wr_console && (!w_full || w_pop);

  assign w_status = {27'b0, r_ovf, r_timeout, r_state, r_pass};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_wr_result || w_expire) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_empty) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Verdict: a RESULT write takes priority over a simultaneous expiry
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_pass    <= 1'b0;
      r_code    <= 32'h0;
      r_timeout <= 1'b0;
    end else if (w_wr_result) begin
      r_pass <= (data_i == PASS_VALUE);
      r_code <= data_i;
    end else if (w_expire) begin
      r_timeout <= 1'b1;
      r_pass    <= 1'b0;
      r_code    <= TIMEOUT_CODE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt   <= '0;
      r_limit <= '0;
    end else if (w_wr_timeout) begin
      r_limit <= CNT_W'(data_i);
      r_cnt   <= '0;
    end else if (w_in_run && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + c_FCNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - c_FCNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_wr_console && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      data_o <= 32'h0;
    end else if (w_rd) begin
      case (addr_i)
        ADDR_W'(0): data_o <= w_status;
        ADDR_W'(1): data_o <= 32'(r_fifo_cnt);
        ADDR_W'(2): data_o <= 32'(r_cnt);
        default:    data_o <= 32'h0;
      endcase
    end
  end

  // Head byte is masked while empty so the stream reads 0 out of reset
  assign char_valid_o = !w_empty;
  assign char_o       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign done_o       = (r_state == ST_DONE);
  assign pass_o       = r_pass;
  assign code_o       = r_code;

`ifdef DEBUG_MONITOR_FINISH_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      if (w_pop) $write("%c", char_o);
      if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DONE)) begin
        if (r_pass) $display("Success!");
        else        $display("Failure! code=%h", r_code);
        $finish;
      end
    end
  end
`else
  // Run outcome is reported only through done_o, pass_o and code_o
`endif

endmodule

`default_nettype wire

// File: tb/tb_debug_monitor.sv
// Self-checking bench for debug_monitor: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
`default_nettype none

module tb_debug_monitor;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        csb_i = 1'b1;
  logic [1:0]  addr_i = 2'd0;
  logic [31:0] data_i = 32'h0;
  logic        data_wen_i = 1'b1;
  logic [31:0] data_o;
  logic        char_valid_o;
  logic [7:0]  char_o;
  logic        char_ready_i = 1'b0;
  logic        done_o;
  logic        pass_o;
  logic [31:0] code_o;

  debug_monitor #(
    .ADDR_W(2), .FIFO_DEPTH(DEPTH), .CNT_W(32),
    .PASS_VALUE(32'h1), .TIMEOUT_CODE(32'hDEAD0001)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .csb_i(csb_i), .addr_i(addr_i),
    .data_i(data_i), .data_wen_i(data_wen_i), .data_o(data_o),
    .char_valid_o(char_valid_o), .char_o(char_o), .char_ready_i(char_ready_i),
    .done_o(done_o), .pass_o(pass_o), .code_o(code_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    csb_i = 1'b0; data_wen_i = 1'b0; addr_i = a; data_i = d;
    tick();
    csb_i = 1'b1; data_wen_i = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    csb_i = 1'b0; data_wen_i = 1'b1; addr_i = a;
    tick();
    d = data_o;
    csb_i = 1'b1;
  endtask

  task automatic do_reset();
    reset_i = 1'b0; csb_i = 1'b1; data_wen_i = 1'b1; char_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
  endtask

  // Reference model: console as a byte queue, phase 0=RUN 1=DRAIN 2=DONE
  byte unsigned m_q[$];
  int           m_phase;
  int unsigned  m_cnt, m_limit;
  bit           m_pass, m_tmo, m_ovf;
  bit [31:0]    m_code, m_dout;

  function automatic void model_reset();
    m_q.delete();
    m_phase = 0; m_cnt = 0; m_limit = 0;
    m_pass = 0; m_tmo = 0; m_ovf = 0; m_code = 0; m_dout = 0;
  endfunction

  function automatic void model_step(input bit wr_en, input bit rd_en, input bit [1:0] a,
                                     input bit [31:0] d, input bit rdy);
    bit was_empty;
    bit expire;
    was_empty = (m_q.size() == 0);
    if (rd_en) begin
      case (a)
        2'd0:    m_dout = {27'b0, m_ovf, m_tmo, 2'(m_phase), m_pass};
        2'd1:    m_dout = 32'(m_q.size());
        2'd2:    m_dout = m_cnt;
        default: m_dout = 0;
      endcase
    end
    if (!was_empty && rdy) void'(m_q.pop_front());
    if (m_phase == 0) begin
      expire = !(wr_en && a == 2) && m_limit != 0 && m_cnt == m_limit - 1;
      if (wr_en && a == 1) begin
        if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
        else m_ovf = 1;
      end
      if (wr_en && a == 2) begin
        m_limit = d; m_cnt = 0;
      end else if (m_cnt != 32'hFFFF_FFFF) begin
        m_cnt++;
      end
      if (wr_en && a == 0) begin
        m_pass = (d == 32'h1); m_code = d; m_phase = 1;
      end else if (expire) begin
        m_tmo = 1; m_pass = 0; m_code = 32'hDEAD0001; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (was_empty) m_phase = 2;
    end
  endfunction

  typedef struct {
    bit        wr;
    bit        rd;
    bit [1:0]  addr;
    bit [31:0] data;
    bit        rdy;
    bit        chk_data;
    bit [31:0] exp_data;
    bit        exp_valid;
    bit [7:0]  exp_char;
    bit        exp_done;
    bit        exp_pass;
    bit [31:0] exp_code;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] rv, rv2;
    int lat;

    // Console 'O','K' held behind ready=0, RESULT=5, then drain
    tbl[0]  = '{1,0,2'd1,32'h4F,0, 0,32'h0, 1,8'h4F, 0,0,32'h0};
    tbl[1]  = '{1,0,2'd1,32'h4B,0, 0,32'h0, 1,8'h4F, 0,0,32'h0};
    tbl[2]  = '{0,1,2'd1,32'h0, 0, 1,32'h2, 1,8'h4F, 0,0,32'h0};
    tbl[3]  = '{1,0,2'd0,32'h5, 0, 0,32'h0, 1,8'h4F, 0,0,32'h5};
    tbl[4]  = '{0,1,2'd0,32'h0, 0, 1,32'h2, 1,8'h4F, 0,0,32'h5};
    tbl[5]  = '{0,0,2'd0,32'h0, 1, 0,32'h0, 1,8'h4B, 0,0,32'h5};
    tbl[6]  = '{0,0,2'd0,32'h0, 1, 0,32'h0, 0,8'h00, 0,0,32'h5};
    tbl[7]  = '{0,0,2'd0,32'h0, 1, 0,32'h0, 0,8'h00, 1,0,32'h5};
    tbl[8]  = '{0,1,2'd0,32'h0, 0, 1,32'h4, 0,8'h00, 1,0,32'h5};
    tbl[9]  = '{1,0,2'd1,32'h5A,0, 0,32'h0, 0,8'h00, 1,0,32'h5};
    tbl[10] = '{0,1,2'd1,32'h0, 0, 1,32'h0, 0,8'h00, 1,0,32'h5};
    tbl[11] = '{0,1,2'd0,32'h0, 0, 1,32'h4, 0,8'h00, 1,0,32'h5};
    tbl[12] = '{0,1,2'd3,32'h0, 0, 1,32'h0, 0,8'h00, 1,0,32'h5};

    // Reset state, then RESULT=1 with an empty FIFO
    do_reset();
    check("rst data_o", data_o, 0);
    check("rst char_valid", char_valid_o, 0);
    check("rst char_o", char_o, 0);
    check("rst done", done_o, 0);
    check("rst pass", pass_o, 0);
    check("rst code", code_o, 0);
    rd(2'd0, rv);
    check("rst status", rv, 0);
    wr(2'd0, 32'h1);
    check("t1 drain done", done_o, 0);
    check("t1 drain pass", pass_o, 1);
    tick();
    check("t1 done", done_o, 1);
    check("t1 pass", pass_o, 1);
    check("t1 code", code_o, 32'h1);
    rd(2'd0, rv);
    check("t1 status", rv, 32'h5);

    // Vector table
    do_reset();
    for (int i = 0; i < 13; i++) begin
      csb_i = !(tbl[i].wr || tbl[i].rd);
      data_wen_i = !tbl[i].wr;
      addr_i = tbl[i].addr;
      data_i = tbl[i].data;
      char_ready_i = tbl[i].rdy;
      tick();
      csb_i = 1'b1; data_wen_i = 1'b1; char_ready_i = 1'b0;
      if (tbl[i].chk_data) check($sformatf("vec%0d data_o", i), data_o, tbl[i].exp_data);
      check($sformatf("vec%0d char_valid", i), char_valid_o, tbl[i].exp_valid);
      check($sformatf("vec%0d char_o", i), char_o, tbl[i].exp_char);
      check($sformatf("vec%0d done", i), done_o, tbl[i].exp_done);
      check($sformatf("vec%0d pass", i), pass_o, tbl[i].exp_pass);
      check($sformatf("vec%0d code", i), code_o, tbl[i].exp_code);
    end

    // Watchdog: limit 100, done seen 101 edges after the write edge
    do_reset();
    wr(2'd2, 32'd100);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (done_o) begin
        lat = k;
        break;
      end
    end
    check("t3 watchdog latency", lat, 101);
    check("t3 pass", pass_o, 0);
    check("t3 code", code_o, 32'hDEAD0001);
    rd(2'd0, rv);
    check("t3 status", rv, 32'hC);
    rd(2'd2, rv);
    check("t3 frozen counter", rv, 32'd100);

    // FIFO full, simultaneous push+pop, then overflow and ordering
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr(2'd1, 32'h10 + i);
    rd(2'd1, rv);
    check("t4 count full", rv, 8);
    rd(2'd0, rv);
    check("t4 no overflow", rv, 0);
    char_ready_i = 1'b1;
    wr(2'd1, 32'h18);
    char_ready_i = 1'b0;
    check("t4 head after push+pop", char_o, 8'h11);
    rd(2'd1, rv);
    check("t4 count push+pop", rv, 8);
    rd(2'd0, rv);
    check("t4 overflow after push+pop", rv, 0);
    wr(2'd1, 32'h19);
    rd(2'd0, rv);
    check("t4 overflow set", rv, 32'h10);
    rd(2'd1, rv);
    check("t4 count after drop", rv, 8);
    char_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("t4 order%0d", i), char_o, 8'h11 + i);
      tick();
    end
    char_ready_i = 1'b0;
    check("t4 drained", char_valid_o, 0);

    // RESULT on the watchdog expiry cycle; later writes ignored
    do_reset();
    wr(2'd2, 32'd10);
    repeat (9) tick();
    wr(2'd0, 32'h1);
    tick();
    check("t5 done", done_o, 1);
    check("t5 pass", pass_o, 1);
    check("t5 code", code_o, 32'h1);
    rd(2'd0, rv);
    check("t5 status", rv, 32'h5);
    wr(2'd0, 32'h7);
    wr(2'd1, 32'h78);
    wr(2'd2, 32'h5);
    check("t5 code after writes", code_o, 32'h1);
    check("t5 valid after writes", char_valid_o, 0);
    rd(2'd2, rv);
    repeat (3) tick();
    rd(2'd2, rv2);
    check("t5 counter value", rv, 32'd10);
    check("t5 counter frozen", rv2, 32'd10);

    // Asynchronous reset mid-DRAIN with 3 bytes queued
    do_reset();
    wr(2'd1, 32'h41);
    wr(2'd1, 32'h42);
    wr(2'd1, 32'h43);
    rd(2'd1, rv);
    check("t6 count pre", rv, 3);
    wr(2'd0, 32'h1);
    reset_i = 1'b0;
    #2;
    check("t6 data_o", data_o, 0);
    check("t6 char_valid", char_valid_o, 0);
    check("t6 char_o", char_o, 0);
    check("t6 done", done_o, 0);
    check("t6 pass", pass_o, 0);
    check("t6 code", code_o, 0);
    #2;
    reset_i = 1'b1;
    rd(2'd1, rv);
    check("t6 count post", rv, 0);
    rd(2'd0, rv);
    check("t6 status post", rv, 0);

    // Randomized traffic against the reference model
    for (int run = 0; run < 16; run++) begin
      int settle;
      do_reset();
      model_reset();
      settle = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        bit        w, r, rdy;
        bit [1:0]  a;
        bit [31:0] d;
        int        pick;
        w = 0; r = 0; a = 0; d = 0;
        rdy = 1'($urandom_range(0, 1));
        pick = $urandom_range(0, 99);
        if (cyc == 0) begin
          w = 1; a = 2; rdy = 0;
          d = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(20, 150);
        end else if (pick < 30) begin
          w = 1; a = 1; d = $urandom;
        end else if (pick < 45) begin
          r = 1; a = 2'($urandom_range(0, 3));
        end else if (pick < 47) begin
          w = 1; a = 0; d = $urandom_range(0, 3);
        end else if (pick < 50) begin
          w = 1; a = 3; d = $urandom;
        end
        csb_i = !(w || r); data_wen_i = !w; addr_i = a; data_i = d; char_ready_i = rdy;
        model_step(w, r, a, d, rdy);
        tick();
        csb_i = 1'b1; data_wen_i = 1'b1; char_ready_i = 1'b0;
        check("rnd char_valid", char_valid_o, m_q.size() != 0);
        if (m_q.size() != 0) check("rnd char_o", char_o, m_q[0]);
        check("rnd done", done_o, m_phase == 2);
        check("rnd pass", pass_o, m_pass);
        check("rnd code", code_o, m_code);
        check("rnd data_o", data_o, m_dout);
        if (m_phase == 2) begin
          settle++;
          if (settle > 4) break;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
